// File: rtl/op_key_conditioner.sv
// op_key_conditioner
//   Front end of the pulse timer. Turns the raw OP push-button into the OP
//   clear/start level that the timer consumes. It also watches the timer's Mo
//   output and uses it to end the run.
//   Btn path: synchroniser -> debouncer -> rising-edge detect -> run-control FSM.
//   Mo path:  synchroniser -> run-control FSM.
//
// Optional feature (macro OP_WATCHDOG_EN):
//   Adds a RUN-state timeout. After WD_CYCLES cycles in RUN without Mo, the
//   run is abandoned and the sticky Err output is raised. Without the macro,
//   Err is tied to 0 and RUN waits indefinitely for Mo.
//
// Ports
//   Clk       in   system clock; all state changes on the rising edge
//   Rst_n     in   synchronous reset, active low
//   Btn       in   raw push-button (asynchronous, active high)
//   Mo        in   timer done level (asynchronous to Clk)
//   OP        out  1 = timer held cleared, 0 = timer running
//   Press     out  one-cycle pulse when a debounced press is accepted
//   Done      out  one-cycle pulse when the run completes on Mo
//   Busy      out  high while the FSM is in RUN
//   Err       out  sticky watchdog error
//   fsm_state out  current FSM state, for debug (0 IDLE, 1 RUN, 2 DONE, 3 REL)
//
// Handshake/timing
//   There is no valid/ready handshake on this block. Press is a strobe that is
//   registered on the IDLE->RUN transition. OP, Busy and Done are registered
//   decodes of the current state, so they lag the state register by one cycle:
//     Btn -> Press : SYNC_STAGES + DB_CYCLES + 1 cycles
//     Mo  -> OP=1  : SYNC_STAGES + 2 cycles
module op_key_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16,
  parameter int DB_CYCLES   = 50000,
  parameter int WD_W        = 24,
  parameter int WD_CYCLES   = 10000000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Btn,
  input  logic       Mo,
  output logic       OP,
  output logic       Press,
  output logic       Done,
  output logic       Busy,
  output logic       Err,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    REL  = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] mo_sync;
  logic                   btn_s;
  logic                   mo_s;
  logic [DB_W-1:0]        db_cnt;
  logic                   btn_db;
  logic                   btn_db_q;
  logic                   rise;
  logic                   wd_hit;

  assign btn_s     = btn_sync[SYNC_STAGES-1];
  assign mo_s      = mo_sync[SYNC_STAGES-1];
  assign rise      = btn_db & ~btn_db_q;
  assign fsm_state = state;

  // Synchronisers and debouncer. The counter only runs while the synchronised
  // key disagrees with the debounced level. Any agreement restarts it, so a
  // glitch shorter than DB_CYCLES can never flip btn_db.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      btn_sync <= '0;
      mo_sync  <= '0;
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], Btn};
      mo_sync  <= {mo_sync[SYNC_STAGES-2:0], Mo};
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef OP_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_hit = (wd_cnt == WD_LAST);
  assign Err    = err_q;

  // The counter is held at zero outside RUN, so it always starts from zero
  // when RUN is entered.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != RUN) wd_cnt <= '0;
      else              wd_cnt <= wd_cnt + 1'b1;
      if (state == RUN && !mo_s && wd_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{WD_W, WD_CYCLES};
  assign wd_hit    = 1'b0;
  assign Err       = 1'b0;
`endif

  // Next-state logic. In IDLE, mo_s is a stale level from the previous run,
  // so it is ignored there; only a fresh press starts a run.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = RUN;
      RUN: begin
        if (mo_s)        state_nxt = DONE;
        else if (wd_hit) state_nxt = REL;
      end
      DONE:    state_nxt = REL;
      REL:     if (!btn_db) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      OP    <= 1'b1;
      Press <= 1'b0;
      Done  <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      OP    <= (state != RUN);
      Busy  <= (state == RUN);
      Done  <= (state == DONE);
      Press <= (state == IDLE) && rise;
    end
  end

endmodule

// File: tb/tb_op_key_conditioner.sv
// tb_op_key_conditioner
//   Directed bench for op_key_conditioner with SYNC_STAGES=2, DB_CYCLES=4 and
//   WD_CYCLES=20. Inputs are driven 2 time units after each rising edge.
//   Outputs are read at the same point. "Step n" means the value seen after
//   the n-th rising edge that follows an input change.
module tb_op_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       mo;
  logic       op;
  logic       press;
  logic       done;
  logic       busy;
  logic       err;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  op_key_conditioner #(
    .SYNC_STAGES(2),
    .DB_W(16),
    .DB_CYCLES(4),
    .WD_W(24),
    .WD_CYCLES(20)
  ) dut (
    .Clk(clk),
    .Rst_n(rst_n),
    .Btn(btn),
    .Mo(mo),
    .OP(op),
    .Press(press),
    .Done(done),
    .Busy(busy),
    .Err(err),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Runs n steps and records Press/Done pulse counts and first positions
  // (0 = none), plus how many steps OP was low.
  task automatic watch(input int n, output int p_cnt, output int p_at,
                       output int d_cnt, output int d_at, output int op_low);
    p_cnt = 0; p_at = 0; d_cnt = 0; d_at = 0; op_low = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (press) begin p_cnt++; if (p_at == 0) p_at = i; end
      if (done)  begin d_cnt++; if (d_at == 0) d_at = i; end
      if (!op) op_low++;
    end
  endtask

  initial begin
    int   p_cnt, p_at, d_cnt, d_at, op_low;
    logic op3, op4, op7, op8, busy8;

    // 1. Reset with Btn and Mo both high
    rst_n = 1'b0; btn = 1'b1; mo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_op", op, 1);
      check("rst_pulses_busy_err", {press, done, busy, err}, 0);
    end
    rst_n = 1'b1; btn = 1'b0; mo = 1'b0;
    step();
    check("rst_state_idle", fsm_state, 0);
    watch(8, p_cnt, p_at, d_cnt, d_at, op_low);

    // 2. Glitch of 3 cycles is rejected
    btn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    btn = 1'b0;
    watch(12, p_cnt, p_at, d_cnt, d_at, op_low);
    check("glitch_no_press", p_cnt, 0);
    check("glitch_op_high", op_low, 0);

    // 3. Clean press: Press at step 7, OP low and Busy high from step 8
    btn = 1'b1;
    p_cnt = 0; p_at = 0; op7 = 1'b0; op8 = 1'b1; busy8 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (press) begin p_cnt++; if (p_at == 0) p_at = i; end
      if (i == 7) op7 = op;
      if (i == 8) begin op8 = op; busy8 = busy; end
    end
    check("press_latency", p_at, 7);
    check("press_count", p_cnt, 1);
    check("press_op_still_high", op7, 1);
    check("run_op_low", op8, 0);
    check("run_busy", busy8, 1);

    // 4. Completion: Done and OP=1 four cycles after Mo
    mo = 1'b1;
    d_cnt = 0; d_at = 0; p_cnt = 0; op3 = 1'b1; op4 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done)  begin d_cnt++; if (d_at == 0) d_at = i; end
      if (press) p_cnt++;
      if (i == 3) op3 = op;
      if (i == 4) op4 = op;
    end
    mo = 1'b0;
    check("done_latency", d_at, 4);
    check("done_count", d_cnt, 1);
    check("done_op_before", op3, 0);
    check("done_op_after", op4, 1);
    check("done_no_press", p_cnt, 0);
    // A held key must not re-trigger
    watch(10, p_cnt, p_at, d_cnt, d_at, op_low);
    check("held_no_press", p_cnt, 0);
    check("held_not_busy", busy, 0);
    // Release for 4 cycles, then press again
    btn = 1'b0;
    watch(4, p_cnt, p_at, d_cnt, d_at, op_low);
    check("release_no_press", p_cnt, 0);
    btn = 1'b1;
    watch(10, p_cnt, p_at, d_cnt, d_at, op_low);
    check("repress_latency", p_at, 7);
    check("repress_count", p_cnt, 1);
    check("repress_busy", busy, 1);

    // 5. Reset during RUN aborts the run without a Done
    rst_n = 1'b0; btn = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_op", op, 1);
    check("abort_busy", busy, 0);
    mo = 1'b1;
    watch(10, p_cnt, p_at, d_cnt, d_at, op_low);
    check("abort_no_done", d_cnt, 0);
    check("abort_no_press", p_cnt, 0);
    check("abort_op_high", op_low, 0);
    mo = 1'b0;
    watch(4, p_cnt, p_at, d_cnt, d_at, op_low);

`ifdef OP_WATCHDOG_EN
    // 6. Watchdog: RUN from step 8, timeout after 20 RUN cycles
    begin
      logic op27, op28, err26, err28;
      btn = 1'b1;
      p_at = 0; d_cnt = 0; op27 = 1'b1; op28 = 1'b0; err26 = 1'b1; err28 = 1'b0;
      for (int i = 1; i <= 30; i++) begin
        step();
        if (press && p_at == 0) p_at = i;
        if (done) d_cnt++;
        if (i == 26) err26 = err;
        if (i == 27) op27 = op;
        if (i == 28) begin op28 = op; err28 = err; end
      end
      check("wd_press", p_at, 7);
      check("wd_op_running", op27, 0);
      check("wd_op_cleared", op28, 1);
      check("wd_err_before", err26, 0);
      check("wd_err_after", err28, 1);
      check("wd_no_done", d_cnt, 0);
      btn = 1'b0;
      watch(10, p_cnt, p_at, d_cnt, d_at, op_low);
      check("wd_err_sticky", err, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("wd_err_reset", err, 0);
    end
`else
    check("err_tied_low", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
